// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcode constants, ALU/PC select codes and the control bundle.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  // One bundle of every datapath control, as produced by the decoder.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
  } ctrl_t;

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational state-to-control decoder. Moore outputs from the state,
// except IRWrite/PCWrite in FETCH (MemReady) and PCWrite in BRANCH (Zero).
module multicycle_output_decode
  import multicycle_controller_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  // Anything not named for a state stays at zero.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIFT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with sticky illegal-opcode flag and a
// saturating retired-instruction counter. Controls are held at zero while
// in reset and for the first edge after release.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUOP_W         = 2,
  parameter int CNT_W           = 16,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instruction,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               Illegal,
  output logic [3:0]         State,
  output logic [CNT_W-1:0]   InstrCount
);

  state_t           state;
  state_t           next_state;
  logic             run;
  logic             illegal;
  logic             retire;
  logic [5:0]       opcode_q;
  logic [CNT_W-1:0] count;
  ctrl_t            ctrl;
  ctrl_t            ctrl_g;
  logic             unused_bits;

  assign unused_bits = ^Instruction[25:0];

  // Next-state selection; retire marks a terminal state returning to FETCH.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:  if (MemReady) next_state = S_DECODE;
      S_DECODE: begin
        case (Instruction[31:26])
          OP_RTYPE:      next_state = S_EXEC;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:       next_state = S_ADDIEX;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: next_state = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) next_state = S_MEMWB;
      S_MEMWR: begin
        if (MemReady) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXEC:   next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: next_state = (HALT_ON_ILLEGAL != 0) ? S_ILLEGAL : S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  // State, opcode capture, sticky illegal flag and saturating counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_FETCH;
      run      <= 1'b0;
      illegal  <= 1'b0;
      opcode_q <= '0;
      count    <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      state <= next_state;
      if (state == S_DECODE) opcode_q <= Instruction[31:26];
      if (state == S_ILLEGAL) illegal <= 1'b1;
      if (retire && (count != {CNT_W{1'b1}})) count <= count + 1'b1;
    end
  end

  multicycle_output_decode u_decode (
    .state     (state),
    .opcode    (opcode_q),
    .zero      (Zero),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign ctrl_g     = run ? ctrl : '0;
  assign IorD       = ctrl_g.iord;
  assign MemRead    = ctrl_g.mem_read;
  assign MemWrite   = ctrl_g.mem_write;
  assign IRWrite    = ctrl_g.ir_write;
  assign RegDst     = ctrl_g.reg_dst;
  assign MemtoReg   = ctrl_g.memto_reg;
  assign RegWrite   = ctrl_g.reg_write;
  assign ALUSrcA    = ctrl_g.alu_src_a;
  assign ALUSrcB    = ctrl_g.alu_src_b;
  assign ALUOp      = ALUOP_W'(ctrl_g.alu_op);
  assign PCSource   = ctrl_g.pc_source;
  assign PCWrite    = ctrl_g.pc_write;
  assign Illegal    = illegal;
  assign State      = state;
  assign InstrCount = count;

endmodule
